// File: rtl/uart_rx_hexdec_fifo.sv
// uart_rx_hexdec_fifo: byte FIFO behind the UART receiver. Each popped byte is decoded as an ASCII hex digit.
// Ports: clk/reset (sync, active-low); rx_data/rx_valid push side; rd_en pop side;
//        oDEC/oBYTE/oERR/oVALID registered pop result; empty/full/count/overflow status.
module uart_rx_hexdec_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          rd_en,
  output logic [3:0]    oDEC,
  output logic [7:0]    oBYTE,
  output logic          oVALID,
  output logic          oERR,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [3:0]    dec_q, dec_d;
  logic [7:0]    byte_q, byte_d;
  logic          vld_q, vld_d;
  logic          err_q, err_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;

  logic          pop_ok;
  logic          push_ok;
  logic [7:0]    pop_byte;

  // Returns {err, nibble}; non-hex characters decode to nibble 0 with err set.
  function automatic logic [4:0] hex_decode(input logic [7:0] b);
    logic [7:0] t;
    t = 8'h00;
    if (b >= 8'h30 && b <= 8'h39) begin
      t = b - 8'h30;
      return {1'b0, t[3:0]};
    end else if (b >= 8'h41 && b <= 8'h46) begin
      t = b - 8'h37;
      return {1'b0, t[3:0]};
    end else if (b >= 8'h61 && b <= 8'h66) begin
      t = b - 8'h57;
      return {1'b0, t[3:0]};
    end
    return {1'b1, 4'h0};
  endfunction

  // A push is still accepted when full if a pop frees a slot in the same cycle.
  assign pop_ok   = rd_en && !empty_q;
  assign push_ok  = rx_valid && (!full_q || pop_ok);
  assign pop_byte = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dec_d    = dec_q;
    byte_d   = byte_q;
    err_d    = err_q;
    vld_d    = 1'b0;
    ovf_d    = ovf_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else if (rx_valid) begin
      // Full with no accompanying pop: the byte is lost.
      ovf_d = 1'b1;
    end

    if (pop_ok) begin
      rd_ptr_d       = rd_ptr_q + AW'(1);
      byte_d         = pop_byte;
      {err_d, dec_d} = hex_decode(pop_byte);
      vld_d          = 1'b1;
    end

    if (push_ok && !pop_ok) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - (AW+1)'(1);
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH_C);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dec_q    <= 4'h0;
      byte_q   <= 8'h00;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dec_q    <= dec_d;
      byte_q   <= byte_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset; contents are only visible through rd_ptr after a push.
  always_ff @(posedge clk) begin
    if (reset && push_ok) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end

  assign oDEC     = dec_q;
  assign oBYTE    = byte_q;
  assign oVALID   = vld_q;
  assign oERR     = err_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule
